// File: rtl/clock_pattern_generator.sv
`default_nettype none
// ============================================================================
// Module      : clock_pattern_generator
// Description : Transmit-side gated clock training pattern generator.
//               Emits ITER_NUM iterations of BURST_LEN toggling cycles
//               followed by IDLE_LEN low cycles on the MB clock lanes.
//               Optional build macro CLKPAT_LOOP_EN: skip DONE and repeat
//               runs continuously (o_done pulses once per run) until i_stop.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_pattern_generator #(
  parameter int BURST_LEN = 16,
  parameter int IDLE_LEN  = 8,
  parameter int ITER_NUM  = 128,
  parameter int CNT_W     = 8
) (
  input  logic             i_dig_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear_results,
  output logic             o_pattern,
  output logic             o_pattern_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_iter_count
);

  // The beat counter is shared by BURST and GAP, so size it for the longer phase.
  localparam int MAX_LEN = (BURST_LEN > IDLE_LEN) ? BURST_LEN : IDLE_LEN;
  localparam int BEAT_W  = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;

  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] GAP_LAST   = BEAT_W'(IDLE_LEN - 1);
  localparam logic [CNT_W-1:0]  ITER_FINAL = CNT_W'(ITER_NUM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pattern_nxt, pattern_en_nxt, busy_nxt, done_nxt;
  logic [CNT_W-1:0]  iter_count_nxt;

  // State, beat counter and all registered outputs; reset is synchronous.
  always_ff @(posedge i_dig_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      beat         <= '0;
      o_pattern    <= 1'b0;
      o_pattern_en <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_iter_count <= '0;
    end else begin
      state        <= state_nxt;
      beat         <= beat_nxt;
      o_pattern    <= pattern_nxt;
      o_pattern_en <= pattern_en_nxt;
      o_busy       <= busy_nxt;
      o_done       <= done_nxt;
      o_iter_count <= iter_count_nxt;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_nxt      = state;
    beat_nxt       = beat;
    pattern_nxt    = 1'b0;
    pattern_en_nxt = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = o_done;
    iter_count_nxt = o_iter_count;
    cnt_inc        = o_iter_count + CNT_W'(1);

    case (state)
      IDLE: begin
        // Stop has priority over a simultaneous start.
        if (i_start && !i_stop) begin
          state_nxt      = BURST;
          beat_nxt       = '0;
          pattern_nxt    = 1'b1;
          pattern_en_nxt = 1'b1;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          iter_count_nxt = '0;
        end
      end

      BURST: begin
`ifdef CLKPAT_LOOP_EN
        done_nxt = 1'b0;
`endif
        if (i_stop) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else if (beat == BURST_LAST) begin
          // Pattern ends low because BURST_LEN is even; GAP holds it low.
          state_nxt = GAP;
          beat_nxt  = '0;
          busy_nxt  = 1'b1;
        end else begin
          beat_nxt       = beat + BEAT_W'(1);
          pattern_nxt    = ~o_pattern;
          pattern_en_nxt = 1'b1;
          busy_nxt       = 1'b1;
        end
      end

      GAP: begin
`ifdef CLKPAT_LOOP_EN
        done_nxt = 1'b0;
`endif
        if (i_stop) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else if (beat == GAP_LAST) begin
          beat_nxt = '0;
          if (cnt_inc == ITER_FINAL) begin
`ifdef CLKPAT_LOOP_EN
            // Run complete: start the next one immediately and flag it.
            state_nxt      = BURST;
            pattern_nxt    = 1'b1;
            pattern_en_nxt = 1'b1;
            busy_nxt       = 1'b1;
            done_nxt       = 1'b1;
            iter_count_nxt = '0;
`else
            state_nxt      = DONE;
            done_nxt       = 1'b1;
            iter_count_nxt = cnt_inc;
`endif
          end else begin
            state_nxt      = BURST;
            pattern_nxt    = 1'b1;
            pattern_en_nxt = 1'b1;
            busy_nxt       = 1'b1;
            iter_count_nxt = cnt_inc;
          end
        end else begin
          beat_nxt = beat + BEAT_W'(1);
          busy_nxt = 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase

    // Clearing results never disturbs the burst/gap phase.
    if (i_clear_results) begin
      done_nxt       = 1'b0;
      iter_count_nxt = '0;
    end
  end

endmodule
`default_nettype wire
